reg_file_param: RTL
===================

// Module: reg_file_param
// PURPOSE
//  Parametrised register file built from enable-gated storage cells: one write port, two
//  independently enabled synchronous read ports. Used in the decode stage of the pipelined
//  CPU; read outputs hold their last value while the read enable is low.
//  Entry 0 is optionally hard-wired to zero.
// PARAMETERS
//  WIDTH     16  data width of each entry, in bits
//  DEPTH     16  number of entries (>=2)
//  ADDR_W     4  address width; must satisfy 2**ADDR_W >= DEPTH
//  ZERO_R0    1  1: entry 0 always reads 0 and writes to it are dropped; 0: ordinary entry
// PORTS
//  clk     in   1       clock; all state updates on the rising edge
//  rst_n   in   1       synchronous active-low reset
//  we      in   1       write enable
//  waddr   in   ADDR_W  write address
//  wdata   in   WIDTH   write data
//  re0     in   1       read enable, port 0
//  raddr0  in   ADDR_W  read address, port 0
//  rdata0  out  WIDTH   registered read data, port 0
//  re1     in   1       read enable, port 1
//  raddr1  in   ADDR_W  read address, port 1
//  rdata1  out  WIDTH   registered read data, port 1
// BEHAVIOUR
//  - Reset: rst_n sampled low at a rising edge -> every entry, rdata0 and rdata1 become 0.
//    Reset has priority over all writes and reads in that cycle.
//  - Write: we=1 at an edge -> entry[waddr] <= wdata. we=0 -> every entry holds.
//  - Read: rei=1 at an edge -> rdatai <= entry[raddri]. rei=0 -> rdatai holds its value.
//    Latency is 1 cycle: address presented in cycle N, data visible after edge N.
//  - Both ports may read the same address in the same cycle; each returns the same value.
//  - Out-of-range address (>= DEPTH when DEPTH < 2**ADDR_W):
//    - Write: dropped.
//    - Read: returns 0.
//  - ZERO_R0=1:
//    - Write to address 0: dropped.
//    - Read of address 0: always returns 0, with or without the bypass.
//  - Same-cycle read/write of one address (we=1, rei=1, raddri==waddr):
//    - Result depends on RF_BYPASS_EN (see CONFIGURATION).
//    - Storage is always updated with wdata.
//  - Reset released mid-stream: the first edge with rst_n=1 performs normal writes and reads.
//    A read in that cycle of an address not being written returns 0.
// CONFIGURATION
//  RF_BYPASS_EN defined:
//    - Same-cycle read/write of one address -> rdatai <= wdata (write-before-read).
//    - The decode stage sees the write-back result without an extra stall.
//    - The ZERO_R0 and out-of-range rules still apply, so reads there return 0.
//  RF_BYPASS_EN undefined:
//    - Same-cycle read/write of one address -> rdatai <= old entry value (read-before-write).
//    - The new value is visible on the next read.
// TESTING
//  1 Reset: drive rst_n=0 for 2 edges, with we=1, waddr=3, wdata=16'hFFFF held throughout.
//    Then rst_n=1 and read addr 3 on both ports -> rdata0 = rdata1 = 16'h0000.
//  2 Write/read: write 16'hA5A5 to addr 5, then re0=1, raddr0=5 next cycle.
//    -> rdata0 = 16'hA5A5 one edge later. rdata1 unchanged while re1=0.
//  3 Hold: set rdata1=16'h1234 from addr 7, then re1=0 and rewrite addr 7 with 16'h5678.
//    -> rdata1 stays 16'h1234 until re1=1, then reads 16'h5678.
//  4 Collision: entry 9 holds 16'h0001. In one cycle write 16'h0002 to addr 9 and read addr 9 on port 0.
//    -> rdata0 = 16'h0002 with RF_BYPASS_EN, 16'h0001 without. A read the next cycle gives 16'h0002 in both builds.
//  5 Zero reg: ZERO_R0=1, write 16'hBEEF to addr 0 while reading addr 0 on both ports.
//    -> both ports read 16'h0000, in this cycle and in later cycles, with and without RF_BYPASS_EN.
//  6 Random: 10k cycles of random we/re/addr/data checked against a reference-model array.
//    Runs with DEPTH=16, WIDTH=16 and with DEPTH=12, WIDTH=32 (out-of-range rules); both macro settings.

Source files
------------

// File: rtl/reg_file_param.sv
// Parametrised register file: one write port, two independently enabled
// registered read ports, optional hard-wired zero entry 0.
// Optional feature macro: RF_BYPASS_EN (same-cycle write-to-read forwarding).
module reg_file_param #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned ADDR_W  = 4,
    parameter bit          ZERO_R0 = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re0,
    input  logic [ADDR_W-1:0] raddr0,
    output logic [WIDTH-1:0]  rdata0,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [WIDTH-1:0]  rdata1
);

    // One extra bit so the bound compare is meaningful when DEPTH == 2**ADDR_W.
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [WIDTH-1:0] rdata0_q, rdata0_d;
    logic [WIDTH-1:0] rdata1_q, rdata1_d;

    // Address maps to a real, writable/readable entry (not out of range, not zero reg).
    function automatic logic addr_live(input logic [ADDR_W-1:0] a);
        logic in_range;
        in_range = ({1'b0, a} < DEPTH_L);
        return in_range && !(ZERO_R0 && (a == '0));
    endfunction

    // Value a read port captures for address a this cycle.
    function automatic logic [WIDTH-1:0] read_entry(input logic [ADDR_W-1:0] a);
        logic [WIDTH-1:0] v;
        v = '0;
        if (addr_live(a)) begin
`ifdef RF_BYPASS_EN
            if (we && (waddr == a)) begin
                v = wdata;
            end else begin
                v = mem_q[a];
            end
`else
            v = mem_q[a];
`endif
        end
        return v;
    endfunction

    // Next storage contents: single write port, dropped writes never match a cell.
    always_comb begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            mem_d[i] = mem_q[i];
            if (we && (waddr == ADDR_W'(i)) && !(ZERO_R0 && (i == 0))) begin
                mem_d[i] = wdata;
            end
        end
    end

    // Read ports capture on enable, hold otherwise.
    always_comb begin
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        if (re0) begin
            rdata0_d = read_entry(raddr0);
        end
        if (re1) begin
            rdata1_d = read_entry(raddr1);
        end
    end

    // State registers with synchronous active-low reset taking priority.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= mem_d[i];
            end
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    assign rdata0 = rdata0_q;
    assign rdata1 = rdata1_q;

endmodule
